cam_stream_gen: RTL
===================

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
- REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line; must be a multiple of 8.
- REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
- REQ-003 SHALL have parameter H_BLANK, default 144: PCLK periods with HREF low after each line's active bytes.
- REQ-004 SHALL have parameter VS_LINES, default 3: line periods with VSYNC high.
- REQ-005 SHALL have parameter VBP, default 17: line periods after VSYNC and before the first active line.
- REQ-006 SHALL have parameter VFP, default 10: line periods after the last active line.
- REQ-007 SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
- REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-009 SHALL have port enable, input, 1 bit: request to stream frames.
- REQ-010 SHALL have port p_clock, output, 1 bit: emulated camera PCLK.
- REQ-011 SHALL have port vsync, output, 1 bit: emulated camera VSYNC, active high.
- REQ-012 SHALL have port href, output, 1 bit: emulated camera HREF, high during active bytes.
- REQ-013 SHALL have port p_data, output, 8 bits: emulated camera data byte.
- REQ-014 SHALL have port frame_done, output, 1 bit: one-clk pulse at the end of each frame.

Function
- REQ-015 SHALL emit an OV7670-style RGB565 stream that a camera_read-style receiver can sample on the rising edge of p_clock.
- REQ-016 SHALL toggle p_clock every clk cycle while not IDLE, so one PCLK period equals 2 clk; p_clock SHALL be held at 0 in IDLE.
- REQ-017 SHALL update vsync, href and p_data only on the clk edge where p_clock goes 1->0, so data is stable for one full clk before and after each rising edge.
- REQ-018 SHALL define a line as H_TOTAL = 2*H_ACTIVE + H_BLANK PCLK periods.
- REQ-019 SHALL use FSM states IDLE, VS, VBACK, ACTIVE, VFRONT.
  - IDLE -> VS when enable=1.
  - VS -> VBACK after VS_LINES lines.
  - VBACK -> ACTIVE after VBP lines.
  - ACTIVE -> VFRONT after V_ACTIVE lines.
  - VFRONT -> VS if enable=1, otherwise IDLE, after VFP lines.
- REQ-020 SHALL drive vsync=1 only in VS; href=0 outside ACTIVE.
- REQ-021 SHALL, within an ACTIVE line, drive href=1 for the first 2*H_ACTIVE PCLK periods and 0 for the remaining H_BLANK periods.
- REQ-022 SHALL send each pixel as two bytes, pixel[15:8] first then pixel[7:0]; row and col SHALL count from 0.
- REQ-023 SHALL hold p_data at 8'h00 whenever href=0.
- REQ-024 SHALL sample enable only in IDLE and at the VFRONT exit; deasserting enable mid-frame SHALL complete the current frame.
- REQ-025 SHALL pulse frame_done for exactly one clk on the final clk of VFRONT.
- REQ-026 SHALL, when VBP=0 or VFP=0, skip the corresponding state with no extra line.

Reset
- REQ-027 SHALL, while reset=1, set the state to IDLE and force p_clock=0, vsync=0, href=0, p_data=8'h00, frame_done=0, and clear all counters.
- REQ-028 SHALL abort any frame in progress when reset asserts; after release, streaming SHALL restart only from VS.

Configuration
- REQ-029 SHALL, with CAM_STREAM_GEN_COLORBAR_EN defined, produce 8 vertical bars of H_ACTIVE/8 pixels each: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- REQ-030 SHALL, without CAM_STREAM_GEN_COLORBAR_EN, produce pixel = (row + col) mod 2^16, a ramp.

Verification
Scenarios use small parameters H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, VS_LINES=1, VBP=1, VFP=1, giving H_TOTAL=10 PCLK and 50 PCLK = 100 clk per frame; macro off unless stated.
- REQ-031 SHALL verify ramp: enable=1 from reset -> bytes sampled on p_clock rises with href=1 are 00 00 00 01 00 02 00 03 for row 0, then 00 01 00 02 00 03 00 04 for row 1.
- REQ-032 SHALL verify timing: enable=1 -> vsync high exactly 20 clk; first href rise 20 clk after vsync falls; href high 16 clk, low 4 clk per line; frame_done every 100 clk.
- REQ-033 SHALL verify enable drop: enable deasserted at clk 30 of a frame -> frame completes, frame_done pulses once, FSM returns to IDLE, p_clock held at 0.
- REQ-034 SHALL verify reset mid-frame: reset pulsed for 1 clk during ACTIVE -> next clk all outputs are 0; with enable=1, vsync rises on the first p_clock 1->0 edge after release.
- REQ-035 SHALL verify colorbar: macro defined, H_ACTIVE=8 -> row 0 bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
- REQ-036 SHALL verify data stability: in every scenario, p_data, href and vsync never change on a clk edge where p_clock rises.

Source files
------------

// File: rtl/cam_stream_gen.sv
// cam_stream_gen -- emulated OV7670-style RGB565 camera source.
//
// Drives a pixel clock and VSYNC/HREF/data the way the sensor does, so a
// camera_read-style receiver can be exercised without real hardware. The
// receiver samples on the rising edge of p_clock. All stream outputs change
// only on the clk edge where p_clock falls, so they are stable for a full clk
// on either side of every rising edge.
//
// Frame layout, in PCLK periods (one PCLK = 2 clk):
//   VS      : VS_LINES lines, vsync=1
//   VBACK   : VBP lines (state skipped when VBP=0)
//   ACTIVE  : V_ACTIVE lines, each 2*H_ACTIVE bytes with href=1, then H_BLANK
//             periods with href=0
//   VFRONT  : VFP lines (state skipped when VFP=0)
// Leaving IDLE costs one lead-in PCLK period with all outputs low before the
// first VS period; back-to-back frames run with no gap.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   enable       stream request; looked at only in IDLE and at frame end,
//                so dropping it mid-frame lets the current frame finish
//   p_clock      emulated PCLK, held low in IDLE
//   vsync, href  emulated sync outputs
//   p_data       byte stream, high byte of each pixel first, 0 when href=0
//   frame_done   one-clk pulse on the final clk of each frame
//
// Build option: define CAM_STREAM_GEN_COLORBAR_EN for 8 vertical colour bars
// instead of the default (row + col) ramp.
module cam_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int VBP      = 17,
  parameter int VFP      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       p_clock,
  output logic       vsync,
  output logic       href,
  output logic [7:0] p_data,
  output logic       frame_done
);

  localparam int H_TOTAL  = 2*H_ACTIVE + H_BLANK;
  localparam int HREF_END = 2*H_ACTIVE;
  localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;

  function automatic int max_of4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int MAX_LINES = max_of4(VS_LINES, VBP, V_ACTIVE, VFP);
  localparam int LW        = $clog2(MAX_LINES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VS     = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  // (state, h_cnt, l_cnt) is the stream position currently on the outputs.
  state_t          state, state_nx, blk_next;
  logic [HW-1:0]   h_cnt, h_nx;
  logic [LW-1:0]   l_cnt, l_nx, lines_cur;
  // run=0 marks the lead-in period after IDLE: the first falling edge only
  // loads the outputs for position (VS,0,0) instead of advancing past it.
  logic            run, run_nx;
  logic            p_clock_nx, frame_done_nx;
  logic            load;
  logic            last_h, last_l, frame_last;

  // Output decode of the next position.
  logic            vsync_d, href_d;
  logic [7:0]      data_d;
  logic [15:0]     col, pix;

  // Lines in the current vertical block.
  always_comb begin
    case (state)
      VS:      lines_cur = LW'(VS_LINES);
      VBACK:   lines_cur = LW'(VBP);
      ACTIVE:  lines_cur = LW'(V_ACTIVE);
      VFRONT:  lines_cur = LW'(VFP);
      default: lines_cur = LW'(1);
    endcase
  end

  assign last_h = (h_cnt == HW'(H_TOTAL - 1));
  assign last_l = (l_cnt == lines_cur - 1'b1);

  // Final PCLK period of a frame; with VFP=0 the frame ends on the last
  // active line.
  assign frame_last = last_h && last_l &&
                      ((state == VFRONT) || ((state == ACTIVE) && (VFP == 0)));

  // Where a finished vertical block goes. Skipped blocks are bypassed here so
  // they cost no line at all.
  always_comb begin
    case (state)
      VS:      blk_next = (VBP > 0) ? VBACK : ACTIVE;
      VBACK:   blk_next = ACTIVE;
      ACTIVE:  blk_next = (VFP > 0) ? VFRONT : (enable ? VS : IDLE);
      VFRONT:  blk_next = enable ? VS : IDLE;
      default: blk_next = IDLE;
    endcase
  end

  // Next-state / position logic.
  always_comb begin
    state_nx      = state;
    h_nx          = h_cnt;
    l_nx          = l_cnt;
    run_nx        = run;
    p_clock_nx    = 1'b0;
    frame_done_nx = 1'b0;
    load          = 1'b0;
    if (state == IDLE) begin
      if (enable) begin
        state_nx   = VS;
        h_nx       = '0;
        l_nx       = '0;
        run_nx     = 1'b0;
        p_clock_nx = 1'b1;
      end
    end else if (!p_clock) begin
      // Rising PCLK edge next: outputs hold. The clk that follows is the
      // last clk of the frame when the current period is the frame's last.
      p_clock_nx    = 1'b1;
      frame_done_nx = frame_last;
    end else begin
      // Falling PCLK edge: advance one period and load outputs.
      p_clock_nx = 1'b0;
      load       = 1'b1;
      run_nx     = 1'b1;
      if (run) begin
        if (!last_h) begin
          h_nx = h_cnt + 1'b1;
        end else begin
          h_nx = '0;
          if (!last_l) begin
            l_nx = l_cnt + 1'b1;
          end else begin
            l_nx     = '0;
            state_nx = blk_next;
            if (blk_next == IDLE) run_nx = 1'b0;
          end
        end
      end
    end
  end

  // Pixel value for the column being sent in the next period.
  assign col = 16'(h_nx >> 1);

`ifdef CAM_STREAM_GEN_COLORBAR_EN
  // Bar width clamps to one pixel so narrow test configurations still work.
  localparam int BAR_W = (H_ACTIVE/8 > 0) ? H_ACTIVE/8 : 1;
  logic [2:0] bar;

  always_comb begin
    bar = 3'(col / 16'(BAR_W));
    case (bar)
      3'd0:    pix = 16'hFFFF;
      3'd1:    pix = 16'hFFE0;
      3'd2:    pix = 16'h07FF;
      3'd3:    pix = 16'h07E0;
      3'd4:    pix = 16'hF81F;
      3'd5:    pix = 16'hF800;
      3'd6:    pix = 16'h001F;
      default: pix = 16'h0000;
    endcase
  end
`else
  logic [15:0] row;

  assign row = 16'(l_nx);
  assign pix = row + col;
`endif

  // Even byte index within the line carries the high byte.
  always_comb begin
    vsync_d = (state_nx == VS);
    href_d  = (state_nx == ACTIVE) && (h_nx < HW'(HREF_END));
    data_d  = 8'h00;
    if (href_d) data_d = h_nx[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      h_cnt      <= '0;
      l_cnt      <= '0;
      run        <= 1'b0;
      p_clock    <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      p_data     <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      h_cnt      <= h_nx;
      l_cnt      <= l_nx;
      run        <= run_nx;
      p_clock    <= p_clock_nx;
      frame_done <= frame_done_nx;
      if (load) begin
        vsync  <= vsync_d;
        href   <= href_d;
        p_data <= data_d;
      end
    end
  end

endmodule
